eth_mac_stats_counters: RTL

Per-event statistics counter bank for the Ethernet MAC FIFO datapath. Takes NUM_EVENTS single-cycle status pulses (tx underflow, tx fifo overflow/bad/good frame, rx bad frame/bad FCS, rx fifo overflow/bad/good frame) and accumulates each into a COUNTER_WIDTH counter. Counters wrap or saturate, with sticky overflow flags. A snapshot command atomically copies all counters into shadow registers, optionally clearing them, and a 1-cycle-latency read port serves the shadow set to a CSR/host block.

---
 rtl/eth_mac_stats_counters.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/eth_mac_stats_counters.sv
// ---------------------------------------------------------------------------
// eth_mac_stats_counters
//
// Statistics counter bank for the Ethernet MAC FIFO datapath. Each of the
// NUM_EVENTS single-cycle status pulses increments its own COUNTER_WIDTH
// counter. A counter either saturates or wraps at all-ones, and in both cases
// it sets a sticky overflow flag. A snapshot command copies every counter and
// the overflow flags into a shadow set in one cycle. When CLEAR_ON_SNAPSHOT=1
// the snapshot also restarts the live counters. The host reads only the
// shadow set, through a read port with one cycle of latency.
//
// Ports:
//   clk           block clock (MAC logic clock domain)
//   reset         asynchronous, active-low reset
//   events        one pulse per event; bit i increments counter i
//   count_enable  1 = events are counted, 0 = events are dropped
//   snapshot      single-cycle command: copy live set into shadow set
//   snapshot_done one-cycle pulse in the cycle after a snapshot
//   rd_req        read strobe
//   rd_addr       read index: 0..NUM_EVENTS-1 are counters,
//                 NUM_EVENTS is the shadow overflow word, higher is an error
//   rd_valid      read response valid, one cycle after rd_req
//   rd_data       read response data (held while no read is returned)
//   rd_err        qualifies rd_valid; 1 = out-of-range address
//   overflow      live sticky overflow flags
// ---------------------------------------------------------------------------
module eth_mac_stats_counters #(
  parameter int NUM_EVENTS        = 9,
  parameter int COUNTER_WIDTH     = 32,
  parameter bit SATURATE          = 1'b1,
  parameter bit CLEAR_ON_SNAPSHOT = 1'b1,
  parameter int ADDR_WIDTH        = $clog2(NUM_EVENTS + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_EVENTS-1:0]    events,
  input  logic                     count_enable,
  input  logic                     snapshot,
  output logic                     snapshot_done,
  input  logic                     rd_req,
  input  logic [ADDR_WIDTH-1:0]    rd_addr,
  output logic                     rd_valid,
  output logic [COUNTER_WIDTH-1:0] rd_data,
  output logic                     rd_err,
  output logic [NUM_EVENTS-1:0]    overflow
);

  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [ADDR_WIDTH-1:0]    OVF_ADDR = ADDR_WIDTH'(NUM_EVENTS);

  logic [COUNTER_WIDTH-1:0] live_cnt   [NUM_EVENTS];
  logic [COUNTER_WIDTH-1:0] live_next  [NUM_EVENTS];
  logic [COUNTER_WIDTH-1:0] shadow_cnt [NUM_EVENTS];
  logic [NUM_EVENTS-1:0]    shadow_ovf;
  logic [NUM_EVENTS-1:0]    ovf_next;
  logic [COUNTER_WIDTH-1:0] shadow_sel;

  // Next value of every live counter and overflow flag. A clearing snapshot
  // overrides the normal update. An event in the snapshot cycle still counts
  // as 1 in the new interval, so that event is neither lost nor counted twice.
  always_comb begin
    for (int i = 0; i < NUM_EVENTS; i++) begin
      live_next[i] = live_cnt[i];
      ovf_next[i]  = overflow[i];
      if (count_enable && events[i]) begin
        if (live_cnt[i] == CNT_MAX) begin
          live_next[i] = SATURATE ? CNT_MAX : '0;
          ovf_next[i]  = 1'b1;
        end else begin
          live_next[i] = live_cnt[i] + COUNTER_WIDTH'(1);
        end
      end
      if (snapshot && CLEAR_ON_SNAPSHOT) begin
        live_next[i] = (count_enable && events[i]) ? COUNTER_WIDTH'(1) : '0;
        ovf_next[i]  = 1'b0;
      end
    end
  end

  // Live counter and overflow state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_EVENTS; i++) live_cnt[i] <= '0;
      overflow <= '0;
    end else begin
      for (int i = 0; i < NUM_EVENTS; i++) live_cnt[i] <= live_next[i];
      overflow <= ovf_next;
    end
  end

  // Shadow set. It captures the live values from before this cycle's
  // increment, so the shadow set matches the interval that just closed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_EVENTS; i++) shadow_cnt[i] <= '0;
      shadow_ovf    <= '0;
      snapshot_done <= 1'b0;
    end else begin
      if (snapshot) begin
        for (int i = 0; i < NUM_EVENTS; i++) shadow_cnt[i] <= live_cnt[i];
        shadow_ovf <= overflow;
      end
      snapshot_done <= snapshot;
    end
  end

  // Select the shadow counter for the read address. The compare loop keeps
  // indexing in range for any NUM_EVENTS that is not a power of two.
  always_comb begin
    shadow_sel = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (rd_addr == ADDR_WIDTH'(i)) shadow_sel = shadow_cnt[i];
    end
  end

  // Read port. A read in the snapshot cycle sees the shadow value from before
  // the snapshot, because the shadow registers update at the same edge.
  // rd_data keeps its value between reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        if (rd_addr < OVF_ADDR) begin
          rd_data <= shadow_sel;
          rd_err  <= 1'b0;
        end else if (rd_addr == OVF_ADDR) begin
          rd_data <= COUNTER_WIDTH'(shadow_ovf);
          rd_err  <= 1'b0;
        end else begin
          rd_data <= '0;
          rd_err  <= 1'b1;
        end
      end
    end
  end

endmodule
